// File: rtl/divsqrt_controller.sv
// ============================================================================
//  Module   : divsqrt_controller
//  Purpose  : Sequencing FSM for the shared iterative divide/square-root
//             fraction datapath, with result valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package exponent;
    typedef enum logic [2:0] {
        ZEROS  = 3'd0,
        ONES   = 3'd1,
        A      = 3'd2,
        B      = 3'd3,
        RESULT = 3'd4
    } exponent_select;
endpackage

module divsqrt_controller #(
    parameter int DIV_ITERS  = 26,
    parameter int SQRT_ITERS = 25
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic                     op_sqrt,
    input  logic [2:0]               special_class,
    input  logic                     flush,
    input  logic                     round_overflow,
    input  logic                     round_underflow,
    output logic                     load,
    output logic                     iterate,
    output logic [4:0]               iter_count,
    output logic                     normalize,
    output logic                     round_en,
    output exponent::exponent_select exponent_select,
    output logic                     overflow_flag,
    output logic                     underflow_flag,
    output logic                     result_valid,
    input  logic                     result_ready
);

    localparam logic [4:0] c_div_load  = 5'(DIV_ITERS - 1);
    localparam logic [4:0] c_sqrt_load = 5'(SQRT_ITERS - 1);

    localparam logic [2:0] c_cls_none   = 3'd0;
    localparam logic [2:0] c_cls_zero   = 3'd1;
    localparam logic [2:0] c_cls_inf    = 3'd2;
    localparam logic [2:0] c_cls_pass_a = 3'd4;
    localparam logic [2:0] c_cls_pass_b = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_ITERATE   = 3'd2,
        S_NORMALIZE = 3'd3,
        S_ROUND     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [4:0]               r_iter;
    logic [4:0]               w_iter_next;
    logic                     r_op_sqrt;
    logic                     w_op_sqrt_next;
    logic                     r_ovf;
    logic                     w_ovf_next;
    logic                     r_unf;
    logic                     w_unf_next;
    exponent::exponent_select r_exp;
    exponent::exponent_select w_exp_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_iter    <= 5'd0;
            r_op_sqrt <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_exp     <= exponent::ZEROS;
        end else begin
            r_state   <= w_state_next;
            r_iter    <= w_iter_next;
            r_op_sqrt <= w_op_sqrt_next;
            r_ovf     <= w_ovf_next;
            r_unf     <= w_unf_next;
            r_exp     <= w_exp_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_iter_next    = r_iter;
        w_op_sqrt_next = r_op_sqrt;
        w_ovf_next     = r_ovf;
        w_unf_next     = r_unf;
        w_exp_next     = r_exp;

        case (r_state)
            S_IDLE: begin
                if (start_valid) begin
                    w_op_sqrt_next = op_sqrt;
                    if (special_class == c_cls_none) begin
                        w_state_next = S_LOAD;
                        w_exp_next   = exponent::ZEROS;
                    end else begin
                        // Special operands skip the datapath; classes 6/7 fall into NaN.
                        w_state_next = S_DONE;
                        case (special_class)
                            c_cls_zero:   w_exp_next = exponent::ZEROS;
                            c_cls_inf:    w_exp_next = exponent::ONES;
                            c_cls_pass_a: w_exp_next = exponent::A;
                            c_cls_pass_b: w_exp_next = exponent::B;
                            default:      w_exp_next = exponent::ONES;
                        endcase
                    end
                end
            end
            S_LOAD: begin
                w_iter_next  = r_op_sqrt ? c_sqrt_load : c_div_load;
                w_state_next = S_ITERATE;
            end
            S_ITERATE: begin
                if (r_iter == 5'd0) begin
                    w_state_next = S_NORMALIZE;
                end else begin
                    w_iter_next = r_iter - 5'd1;
                end
            end
            S_NORMALIZE: begin
                w_state_next = S_ROUND;
            end
            S_ROUND: begin
                // Overflow dominates when the rounder reports both.
                w_ovf_next   = round_overflow;
                w_unf_next   = round_underflow & ~round_overflow;
                w_state_next = S_DONE;
                if (round_overflow) begin
                    w_exp_next = exponent::ONES;
                end else if (round_underflow) begin
                    w_exp_next = exponent::ZEROS;
                end else begin
                    w_exp_next = exponent::RESULT;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    w_state_next = S_IDLE;
                    w_ovf_next   = 1'b0;
                    w_unf_next   = 1'b0;
                    w_exp_next   = exponent::ZEROS;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (flush && (r_state != S_IDLE)) begin
            w_state_next = S_IDLE;
            w_iter_next  = 5'd0;
            w_ovf_next   = 1'b0;
            w_unf_next   = 1'b0;
            w_exp_next   = exponent::ZEROS;
        end
    end

    always_comb begin
        start_ready     = 1'b0;
        load            = 1'b0;
        iterate         = 1'b0;
        normalize       = 1'b0;
        round_en        = 1'b0;
        result_valid    = 1'b0;
        exponent_select = exponent::ZEROS;

        case (r_state)
            S_IDLE:      start_ready = 1'b1;
            S_LOAD:      load        = 1'b1;
            S_ITERATE:   iterate     = 1'b1;
            S_NORMALIZE: begin
                normalize       = 1'b1;
                exponent_select = exponent::RESULT;
            end
            S_ROUND: begin
                round_en        = 1'b1;
                exponent_select = exponent::RESULT;
            end
            S_DONE: begin
                result_valid    = 1'b1;
                exponent_select = r_exp;
            end
            default: start_ready = 1'b0;
        endcase
    end

    assign iter_count     = r_iter;
    assign overflow_flag  = r_ovf;
    assign underflow_flag = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_divsqrt_controller.sv
// ============================================================================
//  Module   : tb_divsqrt_controller
//  Purpose  : Directed self-checking bench for divsqrt_controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divsqrt_controller;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start_valid;
    logic                     start_ready;
    logic                     op_sqrt;
    logic [2:0]               special_class;
    logic                     flush;
    logic                     round_overflow;
    logic                     round_underflow;
    logic                     load;
    logic                     iterate;
    logic [4:0]               iter_count;
    logic                     normalize;
    logic                     round_en;
    exponent::exponent_select exponent_select;
    logic                     overflow_flag;
    logic                     underflow_flag;
    logic                     result_valid;
    logic                     result_ready;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [31:0] c_zeros  = 32'd0;
    localparam logic [31:0] c_ones   = 32'd1;
    localparam logic [31:0] c_a      = 32'd2;
    localparam logic [31:0] c_b      = 32'd3;
    localparam logic [31:0] c_result = 32'd4;

    divsqrt_controller #(.DIV_ITERS(26), .SQRT_ITERS(25)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_valid     (start_valid),
        .start_ready     (start_ready),
        .op_sqrt         (op_sqrt),
        .special_class   (special_class),
        .flush           (flush),
        .round_overflow  (round_overflow),
        .round_underflow (round_underflow),
        .load            (load),
        .iterate         (iterate),
        .iter_count      (iter_count),
        .normalize       (normalize),
        .round_en        (round_en),
        .exponent_select (exponent_select),
        .overflow_flag   (overflow_flag),
        .underflow_flag  (underflow_flag),
        .result_valid    (result_valid),
        .result_ready    (result_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_start_ready"}, 32'(start_ready), 1);
        check_eq({tag, "_result_valid"}, 32'(result_valid), 0);
        check_eq({tag, "_strobes"}, {28'd0, load, iterate, normalize, round_en}, 0);
        check_eq({tag, "_flags"}, {30'd0, overflow_flag, underflow_flag}, 0);
        check_eq({tag, "_iter_count"}, 32'(iter_count), 0);
        check_eq({tag, "_exp"}, 32'(exponent_select), c_zeros);
    endtask

    task automatic accept(input logic sqrt, input logic [2:0] cls);
        start_valid   = 1'b1;
        op_sqrt       = sqrt;
        special_class = cls;
        tick();
        start_valid   = 1'b0;
    endtask

    // Full iterative operation; result_ready held high.
    task automatic run_normal(input string tag, input logic sqrt, input int n,
                              input logic ovf, input logic unf,
                              input logic [31:0] e_exp, input logic e_ovf, input logic e_unf);
        int         iters;
        int         guard;
        logic [4:0] first_cnt;
        logic [4:0] last_cnt;
        round_overflow  = ovf;
        round_underflow = unf;
        result_ready    = 1'b1;
        check_eq({tag, "_pre_ready"}, 32'(start_ready), 1);
        accept(sqrt, 3'd0);
        check_eq({tag, "_load"}, {30'd0, load, iterate}, 32'b10);
        tick();
        iters     = 0;
        guard     = 0;
        first_cnt = iter_count;
        last_cnt  = 5'd31;
        while (iterate && guard < 64) begin
            iters++;
            guard++;
            last_cnt = iter_count;
            tick();
        end
        check_eq({tag, "_iters"}, 32'(iters), 32'(n));
        check_eq({tag, "_first_cnt"}, 32'(first_cnt), 32'(n - 1));
        check_eq({tag, "_last_cnt"}, 32'(last_cnt), 0);
        check_eq({tag, "_normalize"}, 32'(normalize), 1);
        check_eq({tag, "_norm_exp"}, 32'(exponent_select), c_result);
        tick();
        check_eq({tag, "_round_en"}, 32'(round_en), 1);
        tick();
        check_eq({tag, "_valid"}, 32'(result_valid), 1);
        check_eq({tag, "_done_exp"}, 32'(exponent_select), e_exp);
        check_eq({tag, "_flags"}, {30'd0, overflow_flag, underflow_flag}, {30'd0, e_ovf, e_unf});
        tick();
        check_idle({tag, "_after"});
        round_overflow  = 1'b0;
        round_underflow = 1'b0;
    endtask

    task automatic run_special(input string tag, input logic [2:0] cls, input logic [31:0] e_exp);
        result_ready = 1'b1;
        accept(1'b0, cls);
        check_eq({tag, "_valid"}, 32'(result_valid), 1);
        check_eq({tag, "_no_load"}, {30'd0, load, iterate}, 0);
        check_eq({tag, "_exp"}, 32'(exponent_select), e_exp);
        tick();
        check_eq({tag, "_back_idle"}, 32'(start_ready), 1);
    endtask

    initial begin
        int guard;
        int seen_valid;
        reset           = 1'b1;
        start_valid     = 1'b0;
        op_sqrt         = 1'b0;
        special_class   = 3'd0;
        flush           = 1'b0;
        round_overflow  = 1'b0;
        round_underflow = 1'b0;
        result_ready    = 1'b0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        tick();

        run_normal("div",      1'b0, 26, 1'b0, 1'b0, c_result, 1'b0, 1'b0);
        run_normal("sqrt",     1'b1, 25, 1'b0, 1'b0, c_result, 1'b0, 1'b0);
        run_normal("ovf",      1'b0, 26, 1'b1, 1'b0, c_ones,   1'b1, 1'b0);
        run_normal("unf",      1'b1, 25, 1'b0, 1'b1, c_zeros,  1'b0, 1'b1);
        run_normal("both",     1'b0, 26, 1'b1, 1'b1, c_ones,   1'b1, 1'b0);

        run_special("nan",    3'd3, c_ones);
        run_special("pass_b", 3'd5, c_b);
        run_special("pass_a", 3'd4, c_a);
        run_special("zero",   3'd1, c_zeros);
        run_special("inf",    3'd2, c_ones);
        run_special("cls7",   3'd7, c_ones);

        // Backpressure: result held, new requests ignored, result_ready asserted late.
        result_ready = 1'b0;
        accept(1'b0, 3'd5);
        start_valid   = 1'b1;
        special_class = 3'd0;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", 32'(result_valid), 1);
            check_eq("bp_exp", 32'(exponent_select), c_b);
            check_eq("bp_start_ready", 32'(start_ready), 0);
            check_eq("bp_no_load", 32'(load), 0);
            tick();
        end
        start_valid  = 1'b0;
        result_ready = 1'b1;
        tick();
        check_idle("bp_release");

        // Flush partway through iteration.
        accept(1'b0, 3'd0);
        tick();
        for (int i = 0; i < 10; i++) tick();
        check_eq("fl_iterating", 32'(iterate), 1);
        check_eq("fl_count", 32'(iter_count), 15);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_idle("fl_after");
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid) seen_valid++;
            tick();
        end
        check_eq("fl_no_result", 32'(seen_valid), 0);

        // Flush while idle is ignored; the concurrent accept proceeds.
        flush = 1'b1;
        accept(1'b1, 3'd0);
        flush = 1'b0;
        check_eq("fl_idle_accept", 32'(load), 1);

        // Reset while rounding, then a fresh op completes.
        guard = 0;
        while (!round_en && guard < 64) begin
            guard++;
            tick();
        end
        check_eq("rst_in_round", 32'(round_en), 1);
        round_overflow = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        round_overflow = 1'b0;
        check_idle("rst_round");
        run_normal("post_rst", 1'b0, 26, 1'b0, 1'b0, c_result, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
